// File: rtl/mem_dump_reader.sv
// Streams a range of data memory words (with their addresses) out over valid/ready.
// One read outstanding at a time; all outputs registered.
module mem_dump_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_MEM_SIZE = 64,
  localparam int AW           = $clog2(DATA_MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         start_addr_i,
  input  logic [AW:0]           count_i,
  output logic [AW-1:0]         read_addr_o,
  output logic                  read_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [AW-1:0]         out_addr_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [AW:0]   MEM_SIZE = (AW+1)'(DATA_MEM_SIZE);
  localparam logic [AW-1:0] LAST     = AW'(DATA_MEM_SIZE - 1);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cur_q, cur_d;
  logic [AW:0]           rem_q, rem_d;
  logic [AW-1:0]         read_addr_q, read_addr_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         out_addr_q, out_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [AW:0]   start_ext;
  logic [AW-1:0] start_mod;
  logic [AW:0]   count_clamped;
  logic [AW-1:0] next_addr;

  // Out-of-range start addresses fold back into the memory; oversize counts saturate.
  assign start_ext     = {1'b0, start_addr_i};
  assign start_mod     = (start_ext >= MEM_SIZE) ? AW'(start_ext - MEM_SIZE) : start_addr_i;
  assign count_clamped = (count_i > MEM_SIZE) ? MEM_SIZE : count_i;
  assign next_addr     = (cur_q == LAST) ? '0 : cur_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      read_addr_q <= '0;
      read_q      <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      read_addr_q <= read_addr_d;
      read_q      <= read_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    read_addr_d = read_addr_q;
    read_d      = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    // Output registers are loaded with the values of the state being entered.
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (count_clamped != '0) begin
            cur_d       = start_mod;
            rem_d       = count_clamped;
            read_d      = 1'b1;
            read_addr_d = start_mod;
            state_d     = S_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        out_data_d  = read_data_i;
        out_addr_d  = cur_q;
        out_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (rem_q == ONE) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d       = rem_q - ONE;
            cur_d       = next_addr;
            read_d      = 1'b1;
            read_addr_d = next_addr;
            state_d     = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign read_addr_o = read_addr_q;
  assign read_o      = read_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a synchronous-read memory model.
module tb_mem_dump_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] start_addr;
  logic [6:0] count;
  logic [5:0] read_addr;
  logic       rd;
  logic [7:0] read_data;
  logic [7:0] out_data;
  logic [5:0] out_addr;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  mem_dump_reader #(.DATA_WIDTH(8), .DATA_MEM_SIZE(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .count_i      (count),
    .read_addr_o  (read_addr),
    .read_o       (rd),
    .read_data_i  (read_data),
    .out_data_o   (out_data),
    .out_addr_o   (out_addr),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
    mem[4] = 8'd11;
    mem[5] = 8'd22;
    mem[6] = 8'd33;
  end

  always @(posedge clk) if (rd) read_data <= mem[read_addr];

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } word_t;

  word_t wq[$];
  int    rd_cnt   = 0;
  int    done_cnt = 0;
  int    overlap  = 0;
  logic  rd_prev  = 1'b0;

  // Observers sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) wq.push_back({out_addr, out_data});
    if (rd) rd_cnt++;
    if (rd && rd_prev) overlap++;
    rd_prev <= rd;
    if (done) done_cnt++;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [5:0] a, input logic [6:0] c);
    step();
    start      = 1'b1;
    start_addr = a;
    count      = c;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > base) break;
      @(negedge clk);
    end
    step();
    @(negedge clk);
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  int d_base, r_base, w_base;
  logic [7:0] held_d;
  logic [5:0] held_a;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read",      int'(rd), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_read_addr", int'(read_addr), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_addr",  int'(out_addr), 0);
    step();
    rst = 1'b0;

    // Basic dump of mem[4..6] with latency probes.
    out_ready = 1'b1;
    d_base = done_cnt; r_base = rd_cnt; w_base = wq.size();
    issue(6'd4, 7'd3);
    @(negedge clk);
    chk("lat_read_n1",  int'(rd), 1);
    chk("lat_raddr_n1", int'(read_addr), 4);
    chk("lat_busy_n1",  int'(busy), 1);
    chk("lat_ov_n1",    int'(out_valid), 0);
    step(); @(negedge clk);
    chk("lat_read_n2",  int'(rd), 0);
    chk("lat_ov_n2",    int'(out_valid), 0);
    step(); @(negedge clk);
    chk("lat_ov_n3",    int'(out_valid), 1);
    chk("lat_oaddr_n3", int'(out_addr), 4);
    chk("lat_odata_n3", int'(out_data), 11);
    wait_done(d_base, 40, "t1_done_once");
    chk("t1_words", wq.size() - w_base, 3);
    chk("t1_reads", rd_cnt - r_base, 3);
    if (wq.size() - w_base == 3) begin
      chk("t1_w0", int'(wq[w_base]),   int'({6'd4, 8'd11}));
      chk("t1_w1", int'(wq[w_base+1]), int'({6'd5, 8'd22}));
      chk("t1_w2", int'(wq[w_base+2]), int'({6'd6, 8'd33}));
    end
    chk("t1_idle_busy", int'(busy), 0);

    // Backpressure while presenting.
    out_ready = 1'b0;
    d_base = done_cnt; w_base = wq.size();
    issue(6'd10, 7'd2);
    wait_valid(10, "t3_first_valid");
    held_d = out_data;
    held_a = out_addr;
    chk("t3_first_data", int'(held_d), int'(mem[10]));
    chk("t3_first_addr", int'(held_a), 10);
    r_base = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge clk);
      chk("t3_hold_data", int'(out_data), int'(held_d));
      chk("t3_hold_addr", int'(out_addr), int'(held_a));
      chk("t3_hold_valid", int'(out_valid), 1);
    end
    chk("t3_no_read_while_held", rd_cnt - r_base, 0);
    out_ready = 1'b1;
    step(); @(negedge clk);
    chk("t3_req_after_accept", int'(rd), 1);
    chk("t3_req_addr", int'(read_addr), 11);
    chk("t3_ov_dropped", int'(out_valid), 0);
    wait_done(d_base, 40, "t3_done_once");
    chk("t3_words", wq.size() - w_base, 2);
    if (wq.size() - w_base == 2)
      chk("t3_w1", int'(wq[w_base+1]), int'({6'd11, mem[11]}));

    // Address wrap-around at the top of memory.
    d_base = done_cnt; w_base = wq.size();
    issue(6'd62, 7'd4);
    wait_done(d_base, 60, "t4_done_once");
    chk("t4_words", wq.size() - w_base, 4);
    if (wq.size() - w_base == 4) begin
      chk("t4_a0", int'(wq[w_base].a),   62);
      chk("t4_a1", int'(wq[w_base+1].a), 63);
      chk("t4_a2", int'(wq[w_base+2].a), 0);
      chk("t4_a3", int'(wq[w_base+3].a), 1);
      chk("t4_d2", int'(wq[w_base+2].d), int'(mem[0]));
    end

    // Zero-length dump.
    d_base = done_cnt; r_base = rd_cnt; w_base = wq.size();
    issue(6'd7, 7'd0);
    @(negedge clk);
    chk("t5_done_n1", int'(done), 1);
    chk("t5_busy_n1", int'(busy), 1);
    chk("t5_read_n1", int'(rd), 0);
    step(); @(negedge clk);
    chk("t5_done_n2", int'(done), 0);
    chk("t5_busy_n2", int'(busy), 0);
    step(); @(negedge clk);
    chk("t5_no_reads", rd_cnt - r_base, 0);
    chk("t5_no_words", wq.size() - w_base, 0);
    chk("t5_done_once", done_cnt - d_base, 1);

    // Reset while presenting a word.
    out_ready = 1'b0;
    d_base = done_cnt;
    issue(6'd20, 7'd3);
    wait_valid(10, "t6_valid_before_rst");
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_ov",   int'(out_valid), 0);
    chk("t6_rst_read", int'(rd), 0);
    chk("t6_rst_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("t6_no_done", done_cnt - d_base, 0);
    d_base = done_cnt; w_base = wq.size();
    issue(6'd4, 7'd1);
    wait_done(d_base, 30, "t6_restart_done");
    chk("t6_restart_words", wq.size() - w_base, 1);
    if (wq.size() - w_base == 1)
      chk("t6_restart_w0", int'(wq[w_base]), int'({6'd4, 8'd11}));

    // Start held high while busy must be ignored.
    d_base = done_cnt; w_base = wq.size();
    step();
    start = 1'b1; start_addr = 6'd30; count = 7'd2;
    step();
    start_addr = 6'd50; count = 7'd5;
    repeat (3) step();
    start = 1'b0;
    wait_done(d_base, 40, "t7_done_once");
    chk("t7_words", wq.size() - w_base, 2);
    if (wq.size() - w_base == 2) begin
      chk("t7_a0", int'(wq[w_base].a),   30);
      chk("t7_a1", int'(wq[w_base+1].a), 31);
    end

    // Oversize count saturates at the full memory.
    d_base = done_cnt; w_base = wq.size();
    issue(6'd0, 7'd100);
    wait_done(d_base, 300, "t8_done_once");
    chk("t8_words", wq.size() - w_base, 64);
    if (wq.size() - w_base == 64)
      chk("t8_last", int'(wq[w_base+63]), int'({6'd63, mem[63]}));

    chk("one_outstanding", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
